// File: rtl/exu_dp_mc_if.sv
// Bus bundle for the EXU datapath: GPR read/write ports and the ALU
// request/response handshake. The master drives requests, the slave is the datapath.
interface exu_dp_mc_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned GPR_AW = 5
);
    logic [GPR_AW-1:0] gpr_raddr1;
    logic [XLEN-1:0]   gpr_rdata1;
    logic [GPR_AW-1:0] gpr_raddr2;
    logic [XLEN-1:0]   gpr_rdata2;
    logic [GPR_AW-1:0] gpr_waddr;
    logic [XLEN-1:0]   gpr_wdata;
    logic              gpr_wen;

    logic              alu_req_valid;
    logic              alu_req_ready;
    logic [4:0]        alu_opcode;
    logic [XLEN-1:0]   alu_src1;
    logic [XLEN-1:0]   alu_src2;
    logic              alu_rsp_valid;
    logic              alu_rsp_ready;
    logic [XLEN-1:0]   alu_dst;
    logic              alu_rsp_err;
    logic              alu_flush;
    logic              alu_busy;

    modport master (
        output gpr_raddr1, gpr_raddr2, gpr_waddr, gpr_wdata, gpr_wen,
        output alu_req_valid, alu_opcode, alu_src1, alu_src2, alu_rsp_ready, alu_flush,
        input  gpr_rdata1, gpr_rdata2,
        input  alu_req_ready, alu_rsp_valid, alu_dst, alu_rsp_err, alu_busy
    );

    modport slave (
        input  gpr_raddr1, gpr_raddr2, gpr_waddr, gpr_wdata, gpr_wen,
        input  alu_req_valid, alu_opcode, alu_src1, alu_src2, alu_rsp_ready, alu_flush,
        output gpr_rdata1, gpr_rdata2,
        output alu_req_ready, alu_rsp_valid, alu_dst, alu_rsp_err, alu_busy
    );
endinterface

// File: rtl/exu_dp_mc.sv
// EXU datapath: GPR file (x0 hard-wired, optional write bypass) plus a handshaked ALU
// with an iterative radix-2 multiply / restoring-divide engine working on magnitudes.
module exu_dp_mc #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned GPR_AW = 5,
    parameter bit          BYPASS = 1'b1,
    parameter bit          MDU_EN = 1'b1
) (
    input logic        clk,
    input logic        rst_n,
    exu_dp_mc_if.slave bus
);
    localparam int unsigned     NumRegs = 2 ** GPR_AW;
    localparam int unsigned     ShW     = $clog2(XLEN);
    localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [4:0] OpAdd    = 5'd0;
    localparam logic [4:0] OpSub    = 5'd1;
    localparam logic [4:0] OpLessS  = 5'd2;
    localparam logic [4:0] OpLessU  = 5'd3;
    localparam logic [4:0] OpXor    = 5'd4;
    localparam logic [4:0] OpOr     = 5'd5;
    localparam logic [4:0] OpAnd    = 5'd6;
    localparam logic [4:0] OpSl     = 5'd7;
    localparam logic [4:0] OpSrl    = 5'd8;
    localparam logic [4:0] OpSra    = 5'd9;
    localparam logic [4:0] OpMul    = 5'd16;
    localparam logic [4:0] OpMulh   = 5'd17;
    localparam logic [4:0] OpMulhsu = 5'd18;
    localparam logic [4:0] OpMulhu  = 5'd19;
    localparam logic [4:0] OpDiv    = 5'd20;
    localparam logic [4:0] OpDivu   = 5'd21;
    localparam logic [4:0] OpRem    = 5'd22;
    localparam logic [4:0] OpRemu   = 5'd23;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    // ---------------- GPR file ----------------
    logic [XLEN-1:0] gpr_q [NumRegs];
    logic [XLEN-1:0] rdata1, rdata2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NumRegs; i++) begin
                gpr_q[GPR_AW'(i)] <= '0;
            end
        end else if (bus.gpr_wen && (bus.gpr_waddr != '0)) begin
            gpr_q[bus.gpr_waddr] <= bus.gpr_wdata;
        end
    end

    always_comb begin
        rdata1 = gpr_q[bus.gpr_raddr1];
        if (bus.gpr_raddr1 == '0) begin
            rdata1 = '0;
        end else if (BYPASS && bus.gpr_wen && (bus.gpr_raddr1 == bus.gpr_waddr)) begin
            rdata1 = bus.gpr_wdata;
        end
        rdata2 = gpr_q[bus.gpr_raddr2];
        if (bus.gpr_raddr2 == '0) begin
            rdata2 = '0;
        end else if (BYPASS && bus.gpr_wen && (bus.gpr_raddr2 == bus.gpr_waddr)) begin
            rdata2 = bus.gpr_wdata;
        end
    end

    assign bus.gpr_rdata1 = rdata1;
    assign bus.gpr_rdata2 = rdata2;

    // ---------------- ALU state ----------------
    state_e          state_q, state_d;
    logic [4:0]      op_q, op_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, dv_q, dv_d;
    logic            qneg_q, qneg_d, rneg_q, rneg_d;
    logic [ShW-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0] dst_q, dst_d;
    logic            err_q, err_d;
    logic            req_ready;

    // ---------------- Request decode ----------------
    logic [4:0]      op;
    logic [XLEN-1:0] src1, src2, mag1, mag2, imm_res;
    logic [ShW-1:0]  shamt;
    logic            sgn1, sgn2, sa, sb, imm_err, imm_iter;

    always_comb begin
        op       = bus.alu_opcode;
        src1     = bus.alu_src1;
        src2     = bus.alu_src2;
        shamt    = src2[ShW-1:0];
        sgn1     = op inside {OpMulh, OpMulhsu, OpDiv, OpRem};
        sgn2     = op inside {OpMulh, OpDiv, OpRem};
        sa       = sgn1 & src1[XLEN-1];
        sb       = sgn2 & src2[XLEN-1];
        mag1     = sa ? -src1 : src1;
        mag2     = sb ? -src2 : src2;
        imm_res  = '0;
        imm_err  = 1'b0;
        imm_iter = 1'b0;
        case (op)
            OpAdd:   imm_res = src1 + src2;
            OpSub:   imm_res = src1 - src2;
            OpLessS: imm_res = {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)};
            OpLessU: imm_res = {{(XLEN-1){1'b0}}, src1 < src2};
            OpXor:   imm_res = src1 ^ src2;
            OpOr:    imm_res = src1 | src2;
            OpAnd:   imm_res = src1 & src2;
            OpSl:    imm_res = src1 << shamt;
            OpSrl:   imm_res = src1 >> shamt;
            OpSra:   imm_res = $unsigned($signed(src1) >>> shamt);
            OpMul, OpMulh, OpMulhsu, OpMulhu: begin
                if (MDU_EN) imm_iter = 1'b1;
                else        imm_err  = 1'b1;
            end
            OpDiv, OpDivu, OpRem, OpRemu: begin
                // Zero divisor and signed overflow resolve without iterating.
                if (!MDU_EN) begin
                    imm_err = 1'b1;
                end else if (src2 == '0) begin
                    imm_res = (op == OpDiv || op == OpDivu) ? '1 : src1;
                end else if (sgn2 && (src1 == MinNeg) && (src2 == '1)) begin
                    imm_res = (op == OpDiv) ? src1 : '0;
                end else begin
                    imm_iter = 1'b1;
                end
            end
            default: imm_err = 1'b1;
        endcase
    end

    // ---------------- Iteration step and sign fix-up ----------------
    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic [XLEN-1:0]   it_hi, it_lo, fix_res;
    logic [2*XLEN-1:0] prod;

    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dv_q} : '0);
        div_sh   = {hi_q, lo_q[XLEN-1]};
        div_diff = div_sh - {1'b0, dv_q};
        // op_q[2] separates the divide family (20..23) from multiply (16..19).
        if (op_q[2]) begin
            if (!div_diff[XLEN]) begin
                it_hi = div_diff[XLEN-1:0];
                it_lo = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                it_hi = div_sh[XLEN-1:0];
                it_lo = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            it_hi = mul_sum[XLEN:1];
            it_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        prod = {it_hi, it_lo};
        if (qneg_q) prod = -prod;
        case (op_q)
            OpMul:                      fix_res = prod[XLEN-1:0];
            OpMulh, OpMulhsu, OpMulhu:  fix_res = prod[2*XLEN-1:XLEN];
            OpDiv, OpDivu:              fix_res = qneg_q ? -it_lo : it_lo;
            default:                    fix_res = rneg_q ? -it_hi : it_hi;
        endcase
    end

    // ---------------- FSM ----------------
    assign req_ready = (state_q == StIdle) && !bus.alu_flush;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dv_d    = dv_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        cnt_d   = cnt_q;
        dst_d   = dst_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (bus.alu_req_valid && req_ready) begin
                    op_d   = op;
                    cnt_d  = '0;
                    hi_d   = '0;
                    qneg_d = sa ^ sb;
                    rneg_d = sa;
                    if (imm_iter) begin
                        state_d = StBusy;
                        lo_d    = op[2] ? mag1 : mag2;
                        dv_d    = op[2] ? mag2 : mag1;
                    end else begin
                        state_d = StDone;
                        dst_d   = imm_res;
                        err_d   = imm_err;
                    end
                end
            end
            StBusy: begin
                if (bus.alu_flush) begin
                    state_d = StIdle;
                end else begin
                    hi_d  = it_hi;
                    lo_d  = it_lo;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == ShW'(XLEN - 1)) begin
                        state_d = StDone;
                        dst_d   = fix_res;
                        err_d   = 1'b0;
                    end
                end
            end
            StDone: begin
                if (bus.alu_flush || bus.alu_rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dv_q    <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            cnt_q   <= '0;
            dst_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dv_q    <= dv_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            cnt_q   <= cnt_d;
            dst_q   <= dst_d;
            err_q   <= err_d;
        end
    end

    assign bus.alu_req_ready = req_ready;
    assign bus.alu_rsp_valid = (state_q == StDone);
    assign bus.alu_dst       = dst_q;
    assign bus.alu_rsp_err   = err_q;
    assign bus.alu_busy      = (state_q != StIdle);
endmodule

// File: tb/tb_exu_dp_mc.sv
// Directed bench for exu_dp_mc: GPR file, bypass, ALU ops, latency, backpressure,
// flush and reset; ALU results flow through an expected-result queue.
module tb_exu_dp_mc;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned GPR_AW = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    exu_dp_mc_if #(.XLEN(XLEN), .GPR_AW(GPR_AW)) bus ();
    exu_dp_mc_if #(.XLEN(XLEN), .GPR_AW(GPR_AW)) bus_nb ();

    exu_dp_mc #(.XLEN(XLEN), .GPR_AW(GPR_AW), .BYPASS(1'b1), .MDU_EN(1'b1)) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    exu_dp_mc #(.XLEN(XLEN), .GPR_AW(GPR_AW), .BYPASS(1'b0), .MDU_EN(1'b0)) u_dut_nb (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_nb)
    );

    typedef struct {
        logic [31:0] dst;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, scramble inputs after acceptance, then optionally hold off rsp_ready.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] dst, input logic err, input int lat,
                         input int hold);
        exp_t e;
        int   cyc;
        @(negedge clk);
        check("req_ready_idle", 32'(bus.alu_req_ready), 32'd1);
        bus.alu_req_valid = 1'b1;
        bus.alu_opcode    = op;
        bus.alu_src1      = a;
        bus.alu_src2      = b;
        e.dst = dst;
        e.err = err;
        e.lat = lat;
        sb_q.push_back(e);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            bus.alu_req_valid = 1'b0;
            bus.alu_opcode    = 5'($urandom);
            bus.alu_src1      = $urandom;
            bus.alu_src2      = $urandom;
        end while (!bus.alu_rsp_valid && cyc < 100);
        e = sb_q.pop_front();
        check("rsp_latency", 32'(cyc), 32'(e.lat));
        check("rsp_dst", bus.alu_dst, e.dst);
        check("rsp_err", 32'(bus.alu_rsp_err), 32'(e.err));
        for (int i = 0; i < hold; i++) begin
            bus.alu_req_valid = 1'b1;
            @(negedge clk);
            check("hold_valid", 32'(bus.alu_rsp_valid), 32'd1);
            check("hold_dst", bus.alu_dst, e.dst);
            check("hold_req_ready", 32'(bus.alu_req_ready), 32'd0);
        end
        bus.alu_req_valid = 1'b0;
        bus.alu_rsp_ready = 1'b1;
        @(negedge clk);
        bus.alu_rsp_ready = 1'b0;
        check("rsp_drop", 32'(bus.alu_rsp_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst_n = 1'b0;
        bus.gpr_raddr1 = '0; bus.gpr_raddr2 = '0; bus.gpr_waddr = '0;
        bus.gpr_wdata = '0; bus.gpr_wen = 1'b0;
        bus.alu_req_valid = 1'b0; bus.alu_opcode = '0; bus.alu_src1 = '0;
        bus.alu_src2 = '0; bus.alu_rsp_ready = 1'b0; bus.alu_flush = 1'b0;
        bus_nb.gpr_raddr1 = '0; bus_nb.gpr_raddr2 = '0; bus_nb.gpr_waddr = '0;
        bus_nb.gpr_wdata = '0; bus_nb.gpr_wen = 1'b0;
        bus_nb.alu_req_valid = 1'b0; bus_nb.alu_opcode = '0; bus_nb.alu_src1 = '0;
        bus_nb.alu_src2 = '0; bus_nb.alu_rsp_ready = 1'b0; bus_nb.alu_flush = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bus.gpr_raddr1 = 5'd5;
        #1;
        check("rst_rsp_valid", 32'(bus.alu_rsp_valid), 32'd0);
        check("rst_busy", 32'(bus.alu_busy), 32'd0);
        check("rst_dst", bus.alu_dst, 32'd0);
        check("rst_err", 32'(bus.alu_rsp_err), 32'd0);
        check("rst_req_ready", 32'(bus.alu_req_ready), 32'd1);
        check("rst_gpr_x5", bus.gpr_rdata1, 32'd0);

        // GPR write/read and x0
        @(negedge clk);
        bus.gpr_wen = 1'b1; bus.gpr_waddr = 5'd5; bus.gpr_wdata = 32'hDEADBEEF;
        @(negedge clk);
        bus.gpr_wen = 1'b0; bus.gpr_raddr1 = 5'd5; bus.gpr_raddr2 = 5'd0;
        #1;
        check("gpr_x5", bus.gpr_rdata1, 32'hDEADBEEF);
        check("gpr_x0", bus.gpr_rdata2, 32'd0);
        @(negedge clk);
        bus.gpr_wen = 1'b1; bus.gpr_waddr = 5'd0; bus.gpr_wdata = 32'h1234;
        bus.gpr_raddr1 = 5'd0;
        #1;
        check("gpr_x0_bypass", bus.gpr_rdata1, 32'd0);
        @(negedge clk);
        bus.gpr_wen = 1'b0;
        #1;
        check("gpr_x0_write", bus.gpr_rdata1, 32'd0);

        // Bypass on vs off
        @(negedge clk);
        bus.gpr_wen = 1'b1; bus.gpr_waddr = 5'd7; bus.gpr_wdata = 32'h55; bus.gpr_raddr1 = 5'd7;
        bus_nb.gpr_wen = 1'b1; bus_nb.gpr_waddr = 5'd7; bus_nb.gpr_wdata = 32'h55;
        bus_nb.gpr_raddr1 = 5'd7;
        #1;
        check("bypass_on", bus.gpr_rdata1, 32'h55);
        check("bypass_off_old", bus_nb.gpr_rdata1, 32'd0);
        @(negedge clk);
        bus.gpr_wen = 1'b0; bus_nb.gpr_wen = 1'b0;
        #1;
        check("bypass_off_new", bus_nb.gpr_rdata1, 32'h55);
        check("bypass_on_after", bus.gpr_rdata1, 32'h55);

        // Single-cycle ops
        issue(5'd9, 32'h80000000, 32'h24, 32'hF8000000, 1'b0, 1, 0);
        issue(5'd2, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1, 0);
        issue(5'd3, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1, 0);
        issue(5'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1, 0);
        issue(5'd1, 32'h0, 32'h1, 32'hFFFFFFFF, 1'b0, 1, 0);
        issue(5'd7, 32'h1, 32'h3F, 32'h80000000, 1'b0, 1, 0);
        issue(5'd8, 32'h80000000, 32'h1F, 32'h1, 1'b0, 1, 0);
        issue(5'd4, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1, 0);

        // Multiply family
        issue(5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, 33, 0);
        issue(5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33, 0);
        issue(5'd18, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33, 0);
        issue(5'd16, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 33, 0);

        // Divide family incl. corners
        issue(5'd20, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1, 0);
        issue(5'd22, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0, 1, 0);
        issue(5'd21, 32'd9, 32'd0, 32'hFFFFFFFF, 1'b0, 1, 0);
        issue(5'd22, 32'd9, 32'd0, 32'd9, 1'b0, 1, 0);
        issue(5'd22, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, 33, 0);
        issue(5'd20, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 33, 0);
        issue(5'd21, 32'd100, 32'd7, 32'd14, 1'b0, 33, 0);
        issue(5'd23, 32'd100, 32'd7, 32'd2, 1'b0, 33, 0);

        // Illegal opcodes
        issue(5'd31, 32'd5, 32'd6, 32'd0, 1'b1, 1, 0);
        issue(5'd10, 32'd5, 32'd6, 32'd0, 1'b1, 1, 0);

        // Backpressure
        issue(5'd0, 32'd3, 32'd4, 32'd7, 1'b0, 1, 5);

        // Flush mid-divide
        @(negedge clk);
        bus.alu_req_valid = 1'b1; bus.alu_opcode = 5'd20; bus.alu_src1 = 32'd100;
        bus.alu_src2 = 32'd7;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            bus.alu_req_valid = 1'b0;
        end
        bus.alu_flush = 1'b1;
        @(negedge clk);
        bus.alu_flush = 1'b0;
        #1;
        check("flush_rsp_valid", 32'(bus.alu_rsp_valid), 32'd0);
        check("flush_busy", 32'(bus.alu_busy), 32'd0);
        check("flush_req_ready", 32'(bus.alu_req_ready), 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.alu_rsp_valid) seen = 1'b1;
        end
        check("flush_no_rsp", 32'(seen), 32'd0);

        // Flush in IDLE blocks acceptance
        @(negedge clk);
        bus.alu_flush = 1'b1; bus.alu_req_valid = 1'b1; bus.alu_opcode = 5'd0;
        #1;
        check("flush_idle_ready", 32'(bus.alu_req_ready), 32'd0);
        @(negedge clk);
        bus.alu_flush = 1'b0; bus.alu_req_valid = 1'b0;
        #1;
        check("flush_idle_busy", 32'(bus.alu_busy), 32'd0);
        check("flush_idle_rsp", 32'(bus.alu_rsp_valid), 32'd0);

        // MDU_EN=0 instance treats MUL as illegal
        @(negedge clk);
        bus_nb.alu_req_valid = 1'b1; bus_nb.alu_opcode = 5'd16;
        bus_nb.alu_src1 = 32'd3; bus_nb.alu_src2 = 32'd4;
        @(negedge clk);
        bus_nb.alu_req_valid = 1'b0;
        check("nomdu_valid", 32'(bus_nb.alu_rsp_valid), 32'd1);
        check("nomdu_err", 32'(bus_nb.alu_rsp_err), 32'd1);
        check("nomdu_dst", bus_nb.alu_dst, 32'd0);
        bus_nb.alu_rsp_ready = 1'b1;
        @(negedge clk);
        bus_nb.alu_rsp_ready = 1'b0;

        // Reset mid-multiply with a coincident GPR write
        @(negedge clk);
        bus.alu_req_valid = 1'b1; bus.alu_opcode = 5'd16; bus.alu_src1 = 32'd5;
        bus.alu_src2 = 32'd6;
        repeat (5) begin
            @(negedge clk);
            bus.alu_req_valid = 1'b0;
        end
        check("pre_rst_busy", 32'(bus.alu_busy), 32'd1);
        rst_n = 1'b0;
        bus.gpr_wen = 1'b1; bus.gpr_waddr = 5'd9; bus.gpr_wdata = 32'hAA;
        @(negedge clk);
        rst_n = 1'b1;
        bus.gpr_wen = 1'b0; bus.gpr_raddr1 = 5'd9; bus.gpr_raddr2 = 5'd5;
        #1;
        check("midrst_busy", 32'(bus.alu_busy), 32'd0);
        check("midrst_rsp", 32'(bus.alu_rsp_valid), 32'd0);
        check("midrst_x9", bus.gpr_rdata1, 32'd0);
        check("midrst_x5", bus.gpr_rdata2, 32'd0);
        issue(5'd6, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
